// File: rtl/dct_pkg.sv
// Shared types for the 2-D DCT pipeline (row pass, transpose, column pass).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dct_pkg;

  localparam int N      = 8;
  localparam int COEF_W = 16;
  localparam int IDX_W  = $clog2(N);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef logic signed [COEF_W-1:0] dct_coef_t;

  // One 8-lane vector; lane k lives at bits [k*COEF_W +: COEF_W].
  typedef dct_coef_t [N-1:0] vec8_t;

endpackage

// File: rtl/dct_tbank.sv
// Single 8x8 coefficient register bank: row-wide write, column-wide read.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; the parent decides when to write.
//
// Ports:
//   clk      clock
//   we       write enable for one full row
//   wr_row   row index being written
//   wr_data  8 lanes; lane k becomes element (wr_row, k)
//   rd_col   column index being read
//   rd_data  8 lanes; lane r is element (r, rd_col)
module dct_tbank
  import dct_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [N*W-1:0]   wr_data,
  input  logic [IDX_W-1:0] rd_col,
  output logic [N*W-1:0]   rd_data
);

  // mem[row][col]; the row slice has the same lane layout as wr_data,
  // so a whole row is written in one assignment.
  logic [N-1:0][N-1:0][W-1:0] mem;

  // Contents are deliberately left unreset: a bank is only read after
  // all eight rows have been rewritten.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[r*W +: W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose: rows in, columns out, one vector per cycle sustained.
// Latency: column 0 is valid the cycle after row 7 is accepted.
// Backpressure: in_ready drops only while both banks hold unread blocks.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      row handshake; in_data lane k = S[k] of the row
//   out_valid/out_ready    column handshake; out_data lane r = row r at the
//                          current column, zero when out_valid is low
//   out_last               marks column 7 of a block
module dct_transpose
  import dct_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_last
);

  logic [1:0]       full;
  logic             wb;
  logic             rb;
  logic [IDX_W-1:0] wr;
  logic [IDX_W-1:0] rc;

  logic             in_acc;
  logic             out_acc;
  logic             blk_done;
  logic             col_done;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic [N*W-1:0]   rd_data0;
  logic [N*W-1:0]   rd_data1;

  // Both handshake outputs come straight from flag registers, so neither
  // depends combinationally on the opposite side's valid/ready.
  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign out_last  = out_valid && (rc == LAST_IDX);

  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign blk_done = in_acc && (wr == LAST_IDX);
  assign col_done = out_acc && (rc == LAST_IDX);

  // A write can only complete an EMPTY bank and a read can only drain a
  // FULL one, so set and clear never target the same bank in one cycle.
  assign full_set = blk_done ? (2'b01 << wb) : 2'b00;
  assign full_clr = col_done ? (2'b01 << rb) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
      wb   <= 1'b0;
      rb   <= 1'b0;
      wr   <= '0;
      rc   <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (in_acc) begin
        wr <= wr + 1'b1;
        if (wr == LAST_IDX) begin
          wb <= ~wb;
        end
      end
      if (out_acc) begin
        rc <= rc + 1'b1;
        if (rc == LAST_IDX) begin
          rb <= ~rb;
        end
      end
    end
  end

  dct_tbank #(.W(W)) u_bank0 (
    .clk     (clk),
    .we      (in_acc && !wb),
    .wr_row  (wr),
    .wr_data (in_data),
    .rd_col  (rc),
    .rd_data (rd_data0)
  );

  dct_tbank #(.W(W)) u_bank1 (
    .clk     (clk),
    .we      (in_acc && wb),
    .wr_row  (wr),
    .wr_data (in_data),
    .rd_col  (rc),
    .rd_data (rd_data1)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = rb ? rd_data1 : rd_data0;
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Bench for dct_transpose: directed blocks plus random handshaking, checked
// by a queue-based scoreboard drained from a separate monitor process.
module tb_dct_transpose;
  import dct_pkg::*;

  localparam int W = 16;
  typedef logic [N*W-1:0] vec_t;
  typedef struct {
    vec_t dat;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  vec_t       in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  vec_t       out_data;
  logic       out_last;

  exp_t       exp_q[$];
  int         pop_cyc[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         rows_acc = 0;
  int         stall_cnt = 0;
  int         or_mode = 1;   // 0: out_ready low, 1: high, 2: random
  logic [W-1:0] rnd_m[N][N];
  logic       hold_pend = 1'b0;
  vec_t       hold_dat;

  always #5 clk = ~clk;

  dct_transpose #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always @(posedge clk) begin
    cyc++;
    #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: scoreboard pop on every output handshake, plus hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_valid", vec_t'(out_valid), vec_t'(1));
        check("hold_data", out_data, hold_dat);
      end
      hold_pend = out_valid && !out_ready;
      hold_dat  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out actual=%h required=no column", out_data);
        end else begin
          e = exp_q.pop_front();
          check("col_data", out_data, e.dat);
          check("col_last", vec_t'(out_last), vec_t'(e.last));
          pop_cyc.push_back(cyc);
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Hand-written element formulas; kind 2 is a random matrix.
  function automatic logic [W-1:0] f(input int kind, input int r, input int c);
    case (kind)
      0:       return W'(16 * r + c);
      1:       return ((r + c) % 2 == 0) ? 16'h8000 : 16'h7fff;
      2:       return rnd_m[r][c];
      default: return W'(1000 * r - 7 * c - 3000);
    endcase
  endfunction

  task automatic send_row(input vec_t d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 2000) begin
      stall_cnt++;
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout actual=in_ready low required=accepted");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rows_acc++;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int kind, input bit push, input int maxgap, input int nrows);
    vec_t e;
    vec_t row;
    if (push) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < N; r++) e[r*W +: W] = f(kind, r, c);
        exp_q.push_back('{e, (c == N - 1)});
      end
    end
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < N; c++) row[c*W +: W] = f(kind, r, c);
      send_row(row, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", vec_t'(exp_q.size()), vec_t'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, vec_t'(in_ready), vec_t'(1));
    check({tag, "_out_valid"}, vec_t'(out_valid), vec_t'(0));
    check({tag, "_out_last"}, vec_t'(out_last), vec_t'(0));
    check({tag, "_out_data"}, out_data, vec_t'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t row7;
    int   first_k;
    int   acc0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block, latency of column 0
    send_block(0, 1'b1, 0, 7);
    check("lat_before_row7", vec_t'(out_valid), vec_t'(0));
    for (int c = 0; c < N; c++) row7[c*W +: W] = f(0, 7, c);
    send_row(row7, 0);
    check("lat_after_row7", vec_t'(out_valid), vec_t'(1));
    wait_drain();

    // Three blocks back to back: no input stalls, no output gaps
    stall_cnt = 0;
    pop_cyc.delete();
    send_block(3, 1'b1, 0, 8);
    send_block(0, 1'b1, 0, 8);
    send_block(1, 1'b1, 0, 8);
    wait_drain();
    check("b2b_stalls", vec_t'(stall_cnt), vec_t'(0));
    check("b2b_cols", vec_t'(pop_cyc.size()), vec_t'(24));
    if (pop_cyc.size() == 24)
      check("b2b_span", vec_t'(pop_cyc[23] - pop_cyc[0]), vec_t'(23));

    // Output stalled: two banks fill, then release frees one after column 7
    or_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    acc0 = rows_acc;
    fork
      begin
        send_block(0, 1'b1, 0, 8);
        send_block(1, 1'b1, 0, 8);
        send_block(3, 1'b1, 0, 8);
      end
      begin
        repeat (30) @(posedge clk);
        #2;
        check("stall_rows", vec_t'(rows_acc - acc0), vec_t'(16));
        check("stall_in_ready", vec_t'(in_ready), vec_t'(0));
        @(posedge clk);
        or_mode = 1;
        first_k = -1;
        for (int k = 1; k <= 12; k++) begin
          @(posedge clk); #2;
          if (in_ready && first_k < 0) first_k = k;
        end
        check("release_cycle", vec_t'(first_k), vec_t'(8));
      end
    join
    wait_drain();

    // Signed extremes on their own
    send_block(1, 1'b1, 0, 8);
    wait_drain();

    // Random gaps on both sides, 50 blocks
    or_mode = 2;
    for (int b = 0; b < 50; b++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) rnd_m[r][c] = W'($urandom);
      send_block(2, 1'b1, 3, 8);
    end
    @(posedge clk);
    or_mode = 1;
    @(posedge clk); #1;
    wait_drain();

    // Reset mid-block with an unread full block pending
    or_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    send_block(1, 1'b0, 0, 8);
    send_block(0, 1'b0, 0, 5);
    check("pre_reset_valid", vec_t'(out_valid), vec_t'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    or_mode = 1;
    @(posedge clk); #1;
    send_block(3, 1'b1, 0, 8);
    wait_drain();

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dct_transpose.md
# dct_transpose

Ping-pong 8x8 transpose buffer between the row-pass 1-D DCT and the column-pass 1-D DCT of the 2-D JPEG DCT pipeline. Accepts one 8-coefficient row vector per handshake and emits one 8-coefficient column vector per handshake. Two banks allow a block to be written while the previous one drains, so sustained throughput is one vector per cycle.

## Interface
Parameters:
- W, 16: signed coefficient width. Row-DCT output of level-shifted 8-bit samples fits in 12 bits; 16 leaves margin.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  row vector present on in_data.
- in_ready  out  1  buffer can accept a row this cycle.
- in_data  in  8*W  row coefficients; lane k = bits [k*W +: W] = S[k] of that row.
- out_valid  out  1  column vector present on out_data.
- out_ready  in  1  downstream accepts the column this cycle.
- out_data  out  8*W  column vector; lane r = coefficient of row r at the current column.
- out_last  out  1  high with column 7 of a block.

## Operation
- Storage: banks B0, B1, each 8x8 of W-bit signed words. Values are stored and returned bit-exact; no rounding, saturation or sign change.
- Per-bank state: EMPTY or FULL (one flag per bank).
- Write side: bank pointer wb (reset 0), row counter wr (0..7, reset 0).
  - in_ready = !full[wb].
  - On accept (in_valid && in_ready): bank[wb][wr][k] <= lane k for k = 0..7, and wr increments.
  - If wr == 7 on accept: full[wb] <= 1, wr <= 0, wb toggles.
- Read side: bank pointer rb (reset 0), column counter rc (0..7, reset 0).
  - out_valid = full[rb].
  - out_data lane r = bank[rb][r][rc] when out_valid; out_data = 0 when !out_valid.
  - out_last = out_valid && rc == 7.
  - On accept (out_valid && out_ready): rc increments.
  - If rc == 7 on accept: full[rb] <= 0, rc <= 0, rb toggles.
- Simultaneous events:
  - A write completing one bank and a read draining the other bank in the same cycle both take effect.
  - wb and rb never address the same bank while that bank is partially written and being read.
- Both banks FULL: in_ready = 0 until the read side drains column 7 of the older bank.
- Holding in_valid or out_valid high without a handshake changes no state. Upstream must hold in_data stable while in_valid && !in_ready.
- Reset (asserted at any time, including mid-block): wb = rb = 0, wr = rc = 0, both flags EMPTY. Any partial or unread block is discarded. Bank contents are not reset.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
- in_ready and out_valid are decoded from registers only. There is no combinational path from in_valid to in_ready, or from out_ready to in_ready or out_valid.
- A bank freed by draining column 7 in cycle t can accept its first row in cycle t+1.
- Latency: row 7 accepted in cycle t gives out_valid = 1 with column 0 in cycle t+1.
- Throughput: with in_valid and out_ready held high, in_ready never drops and 1 vector per cycle flows in and out. Block n+1 fill overlaps block n drain.

## Structure
- Shared package dct_pkg:
  - localparam N = 8.
  - Coefficient typedef dct_coef_t (logic signed [W-1:0], W = 16).
  - vec8 packed-array typedef, reused by the row and column DCT stages.
- One sub-module, dct_tbank:
  - Single 8x8 register bank.
  - Write port: row index plus 8 lanes.
  - Combinational read port: column index gives 8 lanes.
  - Instantiated twice.
- Top level holds the pointers, counters, flags and handshake logic.

## Test plan
- Single block, ready always high: rows with element (r,c) = 16*r + c → 8 columns out, column c lane r = 16*r + c. out_last on column 7. First out_valid one cycle after row 7 accepted.
- Back-to-back 3 blocks, in_valid and out_ready held high → in_ready stays 1 throughout. 24 columns out, correct per block, no gaps after first latency.
- out_ready held 0 → exactly 16 rows accepted, then in_ready = 0. Releasing out_ready → in_ready returns 1 in the cycle after column 7 of block 0 is accepted.
- Signed extremes: (r,c) = -32768 if (r+c) even, else 32767 → values returned bit-exact.
- Random in_valid/out_ready toggling, 50 blocks → output equals the reference transpose. Handshake-stable checks hold (data steady while valid && !ready).
- rst_n pulsed low after 5 rows of a block → outputs return to reset values immediately. The next full block transposes correctly with no leftover rows.
